issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised out-of-order issue queue between register renaming and register read/execute. Buffers up to DEPTH renamed instructions, tracks per-source-operand readiness by snooping WAKE_PORTS physical-tag broadcasts, and issues the oldest fully-ready entry once per cycle over a valid/ready handshake. Supports a whole-queue flush for branch mispredicts and exposes occupancy.

## Interface
Parameters:
- DEPTH, 8: entry count, ≥2, any integer (not restricted to powers of two).
- PREG_W, 6: physical register tag width.
- PAYLOAD_W, 96: opaque decoded-instruction payload width (rw tag, immediate, control bits, branch target, ...).
- WAKE_PORTS, 2: number of result-tag broadcast ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush, clears all entries.
- in_valid  in  1  renamer offers an instruction.
- in_ready  out  1  queue accepts; enqueue fires when in_valid & in_ready.
- in_rs_tag, in_rt_tag  in  PREG_W each  source physical tags.
- in_rs_rdy, in_rt_rdy  in  1 each  operand already available at rename (also driven 1 when the source is unused).
- in_payload  in  PAYLOAD_W  carried unchanged.
- wake_valid  in  WAKE_PORTS  per-port broadcast valid.
- wake_tag  in  WAKE_PORTS*PREG_W  port p occupies bits [p*PREG_W +: PREG_W].
- out_valid  out  1  an issuable entry is presented.
- out_ready  in  1  downstream accepts; issue fires when out_valid & out_ready.
- out_rs_tag, out_rt_tag  out  PREG_W each.
- out_payload  out  PAYLOAD_W.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full, empty  out  1 each.

## Operation
- Entry state: valid, rs_tag, rs_rdy, rt_tag, rt_rdy, payload, plus age ordering (age matrix or equivalent). An entry is eligible when valid & rs_rdy & rt_rdy.
- Enqueue: written into the lowest-index free slot and marked younger than every valid entry. Tag 0 ($zero) is forced ready on enqueue regardless of the in_*_rdy inputs.
- Wakeup: for every valid entry and each port p with wake_valid[p], a source whose tag equals wake_tag[p] sets its rdy bit. Wakeup also applies to the instruction being enqueued in that same cycle, so no broadcast is lost. Duplicate tags across ports are harmless.
- Select: out_* present the oldest eligible entry, combinationally from registered state. out_valid = 1 iff at least one entry is eligible. On fire, that entry's valid bit is cleared at the edge.
- Backpressure: with out_ready = 0, the presented entry may change in the next cycle if an older entry becomes eligible. Downstream samples only on fire.
- in_ready = ~full & ~flush. A slot freed by an issue is not reusable in the same cycle.
- count is incremented on enqueue fire and decremented on issue fire; it is unchanged when both fire in one cycle. full = (count == DEPTH), empty = (count == 0).
- Flush: all valid bits and count are cleared at the edge. Enqueue is blocked and issue is suppressed during the flush cycle (out_valid forced 0). Wakeups in the flush cycle are discarded.

## Timing
- Reset (async assert, sync-safe deassert): all entries invalid, count = 0, empty = 1, full = 0, in_ready = 1, out_valid = 0, out_* data = 0.
- Enqueue to earliest issue: 1 cycle. An entry enqueued at edge N is presented during cycle N+1 if it is ready.
- Wakeup to issue: a broadcast in cycle N makes its consumer eligible in cycle N+1.
- Throughput: 1 enqueue and 1 issue per cycle, sustained.
- Reset mid-operation discards all contents with no partial state.

## Test plan
- Fill and drain: DEPTH=8, enqueue 8 instructions with both sources ready and out_ready = 0 → after 8 fires full = 1, count = 8, in_ready = 0. Then raise out_ready → issue order is 0..7, one per cycle, ending with empty = 1.
- Out-of-order issue: enqueue A (rs tag 5, not ready), then B (ready) → B issues first. Broadcast wake_tag = 5 on port 1 → A issues on the next cycle.
- Enqueue-cycle wakeup: enqueue C with rt tag 9 not ready while wake_tag[0] = 9 in the same cycle → C issues 1 cycle later.
- Simultaneous events: full queue, issue fires and in_valid = 1 in the same cycle → no enqueue, count goes 8→7, in_ready = 1 in the next cycle.
- Flush: 5 entries held, assert flush together with in_valid and a wakeup → next cycle count = 0, out_valid = 0, the flush-cycle instruction is absent.
- Tag 0 and reset: enqueue with rs tag 0 and in_rs_rdy = 0 → treated as ready. Assert rst_n low mid-stream → outputs take reset values immediately.

Source files
------------

// File: rtl/issue_queue_if.sv
// Rename-side enqueue channel, result-tag wakeup bus, issue-side channel and
// occupancy status of the out-of-order issue queue.
interface issue_queue_if #(
  parameter int DEPTH      = 8,
  parameter int PREG_W     = 6,
  parameter int PAYLOAD_W  = 96,
  parameter int WAKE_PORTS = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [PREG_W-1:0]            in_rs_tag;
  logic [PREG_W-1:0]            in_rt_tag;
  logic                         in_rs_rdy;
  logic                         in_rt_rdy;
  logic [PAYLOAD_W-1:0]         in_payload;
  logic [WAKE_PORTS-1:0]        wake_valid;
  logic [WAKE_PORTS*PREG_W-1:0] wake_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic [PREG_W-1:0]            out_rs_tag;
  logic [PREG_W-1:0]            out_rt_tag;
  logic [PAYLOAD_W-1:0]         out_payload;
  logic [CNT_W-1:0]             count;
  logic                         full;
  logic                         empty;

  modport master (
    output flush, in_valid, in_rs_tag, in_rt_tag, in_rs_rdy, in_rt_rdy, in_payload,
           wake_valid, wake_tag, out_ready,
    input  in_ready, out_valid, out_rs_tag, out_rt_tag, out_payload, count, full, empty
  );

  modport slave (
    input  flush, in_valid, in_rs_tag, in_rt_tag, in_rs_rdy, in_rt_rdy, in_payload,
           wake_valid, wake_tag, out_ready,
    output in_ready, out_valid, out_rs_tag, out_rt_tag, out_payload, count, full, empty
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: buffers renamed instructions, wakes sources on
// result-tag broadcasts and issues the oldest fully-ready entry each cycle.
module issue_queue #(
  parameter int DEPTH      = 8,
  parameter int PREG_W     = 6,
  parameter int PAYLOAD_W  = 96,
  parameter int WAKE_PORTS = 2
) (
  input logic        clk,
  input logic        rst_n,
  issue_queue_if.slave iq
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     vld;
  logic [DEPTH-1:0]     rs_rdy;
  logic [DEPTH-1:0]     rt_rdy;
  logic [PREG_W-1:0]    rs_tag  [DEPTH];
  logic [PREG_W-1:0]    rt_tag  [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  // older[i][j] set means entry i was enqueued before entry j
  logic [DEPTH-1:0]     older   [DEPTH];
  logic [CNT_W-1:0]     count_q;

  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] enq_col;
  logic [DEPTH-1:0] iss_col;
  logic             full;
  logic             enq_fire;
  logic             iss_fire;

  function automatic logic tag_woken(
    input logic [PREG_W-1:0]            tag,
    input logic [WAKE_PORTS-1:0]        wv,
    input logic [WAKE_PORTS*PREG_W-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wv[p] && (wt[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign eligible = vld & rs_rdy & rt_rdy;
  assign enq_fire = iq.in_valid & iq.in_ready;
  assign iss_fire = iq.out_valid & iq.out_ready;
  assign enq_col  = free_oh & {DEPTH{enq_fire}};
  assign iss_col  = sel_oh & {DEPTH{iss_fire}};

  assign iq.in_ready = ~full & ~iq.flush;
  assign iq.full     = full;
  assign iq.empty    = (count_q == '0);
  assign iq.count    = count_q;
  assign iq.out_valid = |sel_oh;

  always_comb begin
    logic found;
    found   = 1'b0;
    free_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // An eligible entry wins when no other eligible entry is older than it
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = eligible[i] & ~iq.flush;
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible[j] && older[j][i]) sel_oh[i] = 1'b0;
      end
    end
  end

  always_comb begin
    iq.out_rs_tag  = '0;
    iq.out_rt_tag  = '0;
    iq.out_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        iq.out_rs_tag  = rs_tag[i];
        iq.out_rt_tag  = rt_tag[i];
        iq.out_payload = payload[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      count_q <= '0;
    end else if (iq.flush) begin
      vld     <= '0;
      count_q <= '0;
    end else begin
      vld <= (vld & ~iss_col) | enq_col;
      case ({enq_fire, iss_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry contents are qualified by vld, so they carry no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_col[i]) begin
        rs_tag[i]  <= iq.in_rs_tag;
        rt_tag[i]  <= iq.in_rt_tag;
        payload[i] <= iq.in_payload;
        rs_rdy[i]  <= iq.in_rs_rdy | (iq.in_rs_tag == '0) |
                      tag_woken(iq.in_rs_tag, iq.wake_valid, iq.wake_tag);
        rt_rdy[i]  <= iq.in_rt_rdy | (iq.in_rt_tag == '0) |
                      tag_woken(iq.in_rt_tag, iq.wake_valid, iq.wake_tag);
        older[i]   <= '0;
      end else begin
        rs_rdy[i] <= rs_rdy[i] | tag_woken(rs_tag[i], iq.wake_valid, iq.wake_tag);
        rt_rdy[i] <= rt_rdy[i] | tag_woken(rt_tag[i], iq.wake_valid, iq.wake_tag);
        older[i]  <= (older[i] & ~enq_col) | (enq_col & {DEPTH{vld[i]}});
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: expected issues are queued as stimulus
// is driven and compared in order whenever an issue handshake fires.
module tb_issue_queue;
  localparam int DEPTH      = 8;
  localparam int PREG_W     = 6;
  localparam int PAYLOAD_W  = 96;
  localparam int WAKE_PORTS = 2;

  typedef struct packed {
    logic [PREG_W-1:0]    rs;
    logic [PREG_W-1:0]    rt;
    logic [PAYLOAD_W-1:0] pl;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb [$];

  issue_queue_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W),
                   .WAKE_PORTS(WAKE_PORTS)) bus ();

  issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W),
                .WAKE_PORTS(WAKE_PORTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iq    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PAYLOAD_W-1:0] mkpl(input int id);
    logic [31:0] hi;
    hi = 32'hC0DE_0000 + 32'(id);
    return {hi, 32'(id * 7), 32'(id)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [PREG_W-1:0] rs, input logic rsr,
                     input logic [PREG_W-1:0] rt, input logic rtr,
                     input int id, input bit expect_issue);
    exp_t e;
    bus.in_valid   = 1'b1;
    bus.in_rs_tag  = rs;
    bus.in_rs_rdy  = rsr;
    bus.in_rt_tag  = rt;
    bus.in_rt_rdy  = rtr;
    bus.in_payload = mkpl(id);
    if (expect_issue) begin
      e.rs = rs; e.rt = rt; e.pl = mkpl(id);
      sb.push_back(e);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.empty; i++) step();
    chk(tag, bus.empty, 1'b1);
  endtask

  // Issue monitor: the handshake seen at the falling edge fires on the next rise
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("issue_unexpected", bus.out_payload, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_payload", bus.out_payload, e.pl);
        chk("issue_tags", {bus.out_rs_tag, bus.out_rt_tag}, {e.rs, e.rt});
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_rs_tag  = '0;
    bus.in_rt_tag  = '0;
    bus.in_rs_rdy  = 1'b0;
    bus.in_rt_rdy  = 1'b0;
    bus.in_payload = '0;
    bus.wake_valid = '0;
    bus.wake_tag   = '0;
    bus.out_ready  = 1'b0;
    step();
    step();
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_payload", bus.out_payload, 0);
    rst_n = 1'b1;
    step();

    // Fill with ready entries under backpressure, then drain in age order
    for (int k = 0; k < DEPTH; k++) enq(6'(k + 10), 1'b1, 6'(k + 20), 1'b1, k, 1'b1);
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, DEPTH);
    chk("fill_in_ready", bus.in_ready, 0);
    chk("fill_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      chk("drain_count", bus.count, DEPTH - 1 - k);
    end
    chk("drain_empty", bus.empty, 1);

    // Younger ready entry overtakes an older waiting one; wake on port 1
    enq(6'd5, 1'b0, 6'd0, 1'b0, 100, 1'b0);
    enq(6'd7, 1'b1, 6'd8, 1'b1, 101, 1'b1);
    step();
    chk("ooo_waiting", bus.out_valid, 0);
    chk("ooo_count", bus.count, 1);
    begin
      exp_t e;
      e.rs = 6'd5; e.rt = 6'd0; e.pl = mkpl(100);
      sb.push_back(e);
    end
    bus.wake_valid = 2'b10;
    bus.wake_tag   = {6'd5, 6'd0};
    step();
    bus.wake_valid = '0;
    chk("ooo_woken", bus.out_valid, 1);
    chk("ooo_woken_tag", bus.out_rs_tag, 6'd5);
    step();
    chk("ooo_empty", bus.empty, 1);

    // Wakeup in the enqueue cycle is not lost
    bus.wake_valid = 2'b01;
    bus.wake_tag   = {6'd0, 6'd9};
    enq(6'd3, 1'b1, 6'd9, 1'b0, 200, 1'b1);
    bus.wake_valid = '0;
    chk("enqwake_valid", bus.out_valid, 1);
    chk("enqwake_payload", bus.out_payload, mkpl(200));
    step();
    chk("enqwake_empty", bus.empty, 1);

    // Full queue: issue fires while the renamer offers; no enqueue that cycle
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) enq(6'(k + 30), 1'b1, 6'(k + 40), 1'b1, 300 + k, 1'b1);
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_rs_tag  = 6'd1;
    bus.in_rs_rdy  = 1'b1;
    bus.in_rt_tag  = 6'd2;
    bus.in_rt_rdy  = 1'b1;
    bus.in_payload = mkpl(399);
    step();
    bus.in_valid = 1'b0;
    chk("simul_count", bus.count, DEPTH - 1);
    chk("simul_in_ready", bus.in_ready, 1);
    wait_empty("simul_drain", 3 * DEPTH);

    // Flush with five held entries, a concurrent enqueue and a wakeup
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) enq(6'(k + 50), 1'b1, 6'(k + 50), 1'b1, 500 + k, 1'b0);
    chk("flush_pre_count", bus.count, 5);
    bus.flush      = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_rs_tag  = 6'd60;
    bus.in_rs_rdy  = 1'b0;
    bus.in_rt_tag  = 6'd61;
    bus.in_rt_rdy  = 1'b1;
    bus.in_payload = mkpl(555);
    bus.wake_valid = 2'b01;
    bus.wake_tag   = {6'd0, 6'd60};
    #1;
    chk("flush_cycle_out_valid", bus.out_valid, 0);
    chk("flush_cycle_in_ready", bus.in_ready, 0);
    step();
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.wake_valid = '0;
    chk("flush_count", bus.count, 0);
    chk("flush_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    step();
    chk("flush_absent", bus.out_valid, 0);
    chk("flush_empty", bus.empty, 1);

    // Tag 0 sources are ready regardless of the rdy inputs
    enq(6'd0, 1'b0, 6'd0, 1'b0, 600, 1'b1);
    chk("tag0_valid", bus.out_valid, 1);
    step();
    chk("tag0_empty", bus.empty, 1);

    // Asynchronous reset in the middle of a stream
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) enq(6'd0, 1'b1, 6'd0, 1'b1, 700 + k, 1'b0);
    chk("prerst_count", bus.count, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", bus.count, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_payload", bus.out_payload, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    enq(6'd11, 1'b1, 6'd12, 1'b1, 800, 1'b1);
    wait_empty("postrst_empty", 10);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
